// File: rtl/adc_capture.sv
// adc_capture: pre/post-trigger ADC sample capture into a circular buffer.
// Ports:
//   i_clk, i_rst        system clock, asynchronous active-high reset
//   i_adc_d             ADC parallel data
//   o_adc_clk, o_adc_noe conversion clock and active-low output enable to the ADC
//   i_arm               single-cycle capture start request
//   i_trig_level, i_trig_rising, i_force  trigger threshold, edge select, forced trigger
//   o_busy, o_done, o_trig_pos            capture status and trigger sample address
//   i_rd_addr, o_rd_data                  registered buffer read port
module adc_capture #(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 8,
  parameter int PRETRIG = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_adc_d,
  output logic              o_adc_clk,
  output logic              o_adc_noe,
  input  logic              i_arm,
  input  logic [7:0]        i_trig_level,
  input  logic              i_trig_rising,
  input  logic              i_force,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_trig_pos,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [7:0]        o_rd_data
);
  localparam int DEPTH  = 2**ADDR_W;
  localparam int POST_N = DEPTH - PRETRIG - 1;
  localparam int DW     = $clog2(CLK_DIV);
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRETRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_N - 1);
  typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, DONE_ST} state_t;
  state_t              r_state, w_state_n;
  logic [DW-1:0]       r_div_cnt;
  logic                r_adc_clk;
  logic                r_noe;
  logic [7:0]          r_adc_q;
  logic [7:0]          r_prev;
  logic [ADDR_W-1:0]   r_wr_ptr, w_wr_ptr_n;
  logic [ADDR_W-1:0]   r_cnt, w_cnt_n;
  logic [ADDR_W-1:0]   r_trig_pos, w_trig_pos_n;
  logic [7:0]          r_rd_data;
  logic [7:0]          r_mem [DEPTH];
  logic                w_stb, w_we, w_cur_hi, w_prev_hi, w_trig;
  assign w_stb     = r_div_cnt == DW'(CLK_DIV - 1);
  assign w_cur_hi  = r_adc_q >= i_trig_level;
  assign w_prev_hi = r_prev >= i_trig_level;
  assign w_trig    = i_force | (i_trig_rising ? (!w_prev_hi & w_cur_hi) : (w_prev_hi & !w_cur_hi));
  assign o_adc_clk  = r_adc_clk;
  assign o_adc_noe  = r_noe;
  assign o_busy     = r_state == PRE || r_state == WAIT_TRIG || r_state == POST;
  assign o_done     = r_state == DONE_ST;
  assign o_trig_pos = r_trig_pos;
  assign o_rd_data  = r_rd_data;
  always_comb begin
    w_state_n    = r_state;
    w_wr_ptr_n   = r_wr_ptr;
    w_cnt_n      = r_cnt;
    w_trig_pos_n = r_trig_pos;
    w_we         = 1'b0;
    case (r_state)
      IDLE, DONE_ST: if (i_arm) begin
        w_state_n  = PRE;
        w_wr_ptr_n = '0;
        w_cnt_n    = '0;
      end
      PRE: if (w_stb) begin
        w_we       = 1'b1;
        w_wr_ptr_n = r_wr_ptr + 1'b1;
        w_cnt_n    = r_cnt + 1'b1;
        w_state_n  = r_cnt == PRE_LAST ? WAIT_TRIG : PRE;
      end
      WAIT_TRIG: if (w_stb) begin
        w_we       = 1'b1;
        w_wr_ptr_n = r_wr_ptr + 1'b1;
        if (w_trig) begin
          w_trig_pos_n = r_wr_ptr;
          w_cnt_n      = '0;
          // With PRETRIG = DEPTH-1 there is nothing left to write after the trigger.
          w_state_n    = POST_N == 0 ? DONE_ST : POST;
        end
      end
      POST: if (w_stb) begin
        w_we       = 1'b1;
        w_wr_ptr_n = r_wr_ptr + 1'b1;
        w_cnt_n    = r_cnt + 1'b1;
        w_state_n  = r_cnt == POST_LAST ? DONE_ST : POST;
      end
      default: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_div_cnt  <= '0;
      r_adc_clk  <= 1'b0;
      r_noe      <= 1'b1;
      r_adc_q    <= '0;
      r_prev     <= '0;
      r_wr_ptr   <= '0;
      r_cnt      <= '0;
      r_trig_pos <= '0;
    end else begin
      r_state    <= w_state_n;
      r_div_cnt  <= w_stb ? '0 : r_div_cnt + 1'b1;
      r_adc_clk  <= r_div_cnt < DW'(CLK_DIV / 2);
      r_noe      <= 1'b0;
      r_adc_q    <= i_adc_d;
      r_prev     <= w_stb ? r_adc_q : r_prev;
      r_wr_ptr   <= w_wr_ptr_n;
      r_cnt      <= w_cnt_n;
      r_trig_pos <= w_trig_pos_n;
    end
  end
  // Buffer contents survive reset so a completed capture can still be read.
  always_ff @(posedge i_clk) begin
    if (w_we) r_mem[r_wr_ptr] <= r_adc_q;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_rd_data <= '0;
    else       r_rd_data <= r_mem[i_rd_addr];
  end
endmodule

// File: tb/tb_adc_capture.sv
// tb_adc_capture: randomized and directed capture runs checked against a sample-level model.
module tb_adc_capture;
  localparam int PRETRIG = 64;
  localparam int DEPTH   = 256;
  logic       clk = 0;
  logic       rst = 0;
  logic [7:0] adc_d = 0;
  logic       adc_clk, adc_noe;
  logic       arm = 0;
  logic [7:0] lvl = 8'h80;
  logic       rising = 1;
  logic       frc = 0;
  logic       busy, done;
  logic [7:0] trig_pos;
  logic [7:0] rd_addr = 0;
  logic [7:0] rd_data;
  int         checks = 0;
  int         errors = 0;
  int         cyc;
  logic [7:0] hist [0:2047];
  logic [7:0] exp_mem [0:DEPTH-1];
  logic       v [8];
  adc_capture #(.CLK_DIV(4), .ADDR_W(8), .PRETRIG(PRETRIG)) dut (
    .i_clk(clk), .i_rst(rst), .i_adc_d(adc_d), .o_adc_clk(adc_clk), .o_adc_noe(adc_noe),
    .i_arm(arm), .i_trig_level(lvl), .i_trig_rising(rising), .i_force(frc),
    .o_busy(busy), .o_done(done), .o_trig_pos(trig_pos), .i_rd_addr(rd_addr), .o_rd_data(rd_data)
  );
  always #5 clk = ~clk;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic align();
    while (cyc % 4 != 0) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
    rd_addr = a;
    @(posedge clk);
    #1 chk(tag, rd_data, exp);
  endtask
  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) rd(8'(a), exp_mem[a], "readback");
  endtask
  task automatic reset_checks(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_trig_pos"}, trig_pos, 0);
    chk({tag, "_adc_clk"}, adc_clk, 0);
    chk({tag, "_noe"}, adc_noe, 1);
    chk({tag, "_rd_data"}, rd_data, 0);
  endtask
  // mode 0: ramp, 1: step from va to vb at sample sw, 2: random.
  // Returns the trigger sample index seen by the model (-1 if stopped early or timed out).
  task automatic capture(input int mode, input int sw, input logic [7:0] va, input logic [7:0] vb,
                         input int force_at, input int arm_at, input int stop_at, output int t);
    int last;
    logic [7:0] s, prev;
    logic rdc;
    align();
    t = -1;
    last = -1;
    prev = 0;
    for (int i = 0; i < 2000; i++) begin
      s = mode == 0 ? 8'(i) : mode == 2 ? 8'($urandom) : (i < sw ? va : vb);
      hist[i] = s;
      adc_d = s;
      frc = i == force_at;
      arm = i == 0 || i == arm_at;
      rdc = t >= 0 && i == t + 5;
      if (rdc) rd_addr = 8'(t);
      @(posedge clk);
      #1 arm = 0;
      if (i == 0) chk("busy_after_arm", busy, 1);
      if (rdc) chk("rd_in_post", rd_data, hist[t]);
      repeat (3) @(posedge clk);
      #1;
      if (t < 0 && i >= PRETRIG &&
          (frc || (rising ? (prev < lvl && s >= lvl) : (prev >= lvl && s < lvl)))) begin
        t = i;
        last = i + DEPTH - PRETRIG - 1;
      end
      prev = s;
      exp_mem[i % DEPTH] = s;
      if (i == stop_at) begin
        frc = 0;
        t = -1;
        return;
      end
      chk("done", done, i == last);
      chk("busy", busy, i != last);
      if (i == last) break;
    end
    frc = 0;
    chk("capture_completed", last >= 0, 1);
    if (t >= 0) chk("trig_pos", trig_pos, t % DEPTH);
  endtask
  initial begin
    int t;
    int hi;
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 reset_checks("reset");
    rst = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1 v[k] = adc_clk;
      chk("noe_after_release", adc_noe, 0);
    end
    hi = 0;
    for (int k = 0; k < 4; k++) begin
      chk("adc_clk_period", v[k], v[k+4]);
      hi += int'(v[k]);
    end
    chk("adc_clk_duty", hi, 2);
    chk("adc_clk_shape02", v[0] ^ v[2], 1);
    chk("adc_clk_shape13", v[1] ^ v[3], 1);
    // Ramp with rising trigger at 0x80.
    lvl = 8'h80; rising = 1;
    capture(0, 0, 0, 0, -1, -1, -1, t);
    chk("ramp_trig_pos", trig_pos, 128);
    rd(8'd64, 8'h40, "ramp_rd64");
    rd(8'd128, 8'h80, "ramp_rd128");
    rd(8'd63, 8'h3F, "ramp_rd63");
    read_all();
    // Step inside PRE then constant: only FORCE can trigger.
    capture(1, 10, 8'h00, 8'hFF, 100, -1, -1, t);
    chk("force_trig_pos", trig_pos, 100);
    read_all();
    // Threshold boundaries.
    rising = 0;
    capture(1, 100, 8'h80, 8'h7F, -1, -1, -1, t);
    chk("falling_80_7f", trig_pos, 100);
    rising = 1;
    capture(1, 100, 8'h7F, 8'h80, -1, -1, -1, t);
    chk("rising_7f_80", trig_pos, 100);
    capture(1, 100, 8'h80, 8'h81, 150, -1, -1, t);
    chk("rising_80_81_no_trig", trig_pos, 150);
    read_all();
    // ARM during POST must be ignored.
    capture(0, 0, 0, 0, -1, 200, -1, t);
    chk("arm_in_post_trig_pos", trig_pos, 128);
    // Reset during POST aborts; re-arm starts clean.
    capture(0, 0, 0, 0, -1, -1, 200, t);
    rst = 1;
    #1 reset_checks("rst_in_post");
    @(posedge clk);
    #1 rst = 0;
    capture(0, 0, 0, 0, -1, -1, -1, t);
    chk("rearm_trig_pos", trig_pos, 128);
    read_all();
    // Random data, level and edge.
    for (int r = 0; r < 3; r++) begin
      lvl = 8'($urandom);
      rising = 1'($urandom);
      capture(2, 0, 0, 0, 600, -1, -1, t);
      read_all();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_capture.md
ADC_CAPTURE -- requirements
Module: adc_capture

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning CLK cycles per ADC_CLK period (even, >=2).
REQ-002 SHALL have parameter ADDR_W, default 8, meaning buffer address width; DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter PRETRIG, default 64, meaning samples kept before trigger (1 <= PRETRIG < DEPTH).
REQ-004 SHALL have CLK  in  1  system clock (100 MHz); all logic on its rising edge.
REQ-005 SHALL have RST  in  1  reset; asynchronous, active-high.
REQ-006 SHALL have ADC_D  in  8  ADC parallel data (unsigned).
REQ-007 SHALL have ADC_CLK  out  1  conversion clock to the ADC.
REQ-008 SHALL have ADC_nOE  out  1  ADC output enable, active-low.
REQ-009 SHALL have ARM  in  1  single-cycle start request.
REQ-010 SHALL have TRIG_LEVEL  in  8  trigger threshold (unsigned).
REQ-011 SHALL have TRIG_RISING  in  1  1 = rising-edge trigger, 0 = falling-edge.
REQ-012 SHALL have FORCE  in  1  level; forces a trigger.
REQ-013 SHALL have BUSY  out  1  capture in progress.
REQ-014 SHALL have DONE  out  1  buffer holds a complete capture.
REQ-015 SHALL have TRIG_POS  out  ADDR_W  buffer address of the trigger sample.
REQ-016 SHALL have RD_ADDR  in  ADDR_W, and RD_DATA  out  8; the buffer read port.

Function
REQ-017 SHALL run divider counter div_cnt 0..CLK_DIV-1, wrapping; ADC_CLK = 1 while div_cnt < CLK_DIV/2, else 0, registered.
REQ-018 SHALL register ADC_D every CLK into adc_q; sample strobe = the cycle div_cnt == CLK_DIV-1; the sample is adc_q in that cycle.
REQ-019 SHALL drive ADC_nOE = 0 on every cycle after reset release.
REQ-020 SHALL implement FSM states IDLE, PRE, WAIT_TRIG, POST, DONE_ST.
REQ-021 IDLE/DONE_ST + ARM -> PRE; wr_ptr := 0, sample counter := 0, DONE := 0, BUSY := 1, next cycle.
REQ-022 SHALL ignore ARM while BUSY = 1.
REQ-023 PRE: each strobe writes sample to mem[wr_ptr], wr_ptr += 1; after PRETRIG writes -> WAIT_TRIG; trigger conditions are ignored in PRE.
REQ-024 WAIT_TRIG: each strobe writes circularly (wr_ptr wraps DEPTH-1 -> 0) and evaluates the trigger on the same sample.
REQ-025 Rising trigger SHALL be prev < TRIG_LEVEL and cur >= TRIG_LEVEL; falling SHALL be prev >= TRIG_LEVEL and cur < TRIG_LEVEL; prev = previous strobed sample.
REQ-026 FORCE = 1 at a WAIT_TRIG strobe SHALL trigger on that sample regardless of level.
REQ-027 On trigger: TRIG_POS := wr_ptr of the triggering sample; state -> POST.
REQ-028 POST: SHALL write exactly DEPTH-PRETRIG-1 further samples, then -> DONE_ST: DONE = 1, BUSY = 0, writes stop.
REQ-029 On completion, the oldest sample SHALL be at (TRIG_POS-PRETRIG) mod DEPTH and the newest at (TRIG_POS-PRETRIG-1) mod DEPTH.
REQ-030 RD_DATA SHALL be mem[RD_ADDR] registered, 1 CLK latency, available in every state; contents are undefined where not yet written.
REQ-031 Read and write to the same address in the same cycle SHALL return the old data.

Reset
REQ-032 RST = 1 SHALL immediately force: state IDLE, div_cnt 0, ADC_CLK 0, ADC_nOE 1, BUSY 0, DONE 0, TRIG_POS 0, wr_ptr 0, RD_DATA 0.
REQ-033 RST mid-capture SHALL abort to IDLE; buffer memory is not cleared; a new ARM after release SHALL start a clean capture.

Verification
REQ-034 Reset: RST high -> all REQ-032 values; after release ADC_CLK has period 4 CLK (2 high/2 low) and ADC_nOE = 0.
REQ-035 Ramp: ADC_D steps +1 per strobe from 0x00 at the first post-ARM sample; TRIG_LEVEL 0x80, rising -> TRIG_POS = 128; DONE after 191 post samples; RD_ADDR 64 -> 0x40, RD_ADDR 128 -> 0x80, RD_ADDR 63 -> 0x3F.
REQ-036 A 0x00 -> 0xFF step at sample 10 (inside PRE) followed by constant 0xFF -> no trigger; FORCE = 1 -> trigger at the next strobe, DONE 191 strobes later.
REQ-037 Threshold boundary at TRIG_LEVEL 0x80: falling, 0x80 -> 0x7F triggers; rising, 0x7F -> 0x80 triggers; rising, 0x80 -> 0x81 does not.
REQ-038 ARM pulsed during POST -> ignored (TRIG_POS unchanged, DONE at the normal time); RST pulsed during POST -> BUSY 0, DONE 0; re-ARM -> BUSY 1 the next cycle.
REQ-039 Read port: RD_ADDR changed at cycle n -> RD_DATA reflects the new address at cycle n+1, in both DONE_ST and POST.
